// File: rtl/led_flow_pkg.sv
// Shared encodings for the LED-flow sequencer: pattern modes, FSM states, ping-pong direction.
package led_flow_pkg;

    typedef enum logic [1:0] {
        MODE_SHIFT_L  = 2'd0,
        MODE_SHIFT_R  = 2'd1,
        MODE_FILL     = 2'd2,
        MODE_PINGPONG = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RELOAD = 2'd2
    } state_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate divider for the LED-flow sequencer: speed level with saturation, cycle counter,
// registered tick strobe and a same-cycle step request for the pattern register.
module led_tick_gen
    import led_flow_pkg::*;
#(
    parameter int BASE_DIV = 250000,
    parameter int N_SPEED  = 4
) (
    input  logic                       clkin,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       clr,
    input  logic                       speed_up,
    input  logic                       speed_dn,
    output logic [$clog2(N_SPEED)-1:0] speed,
    output logic                       tick,
    output logic                       step
);

    localparam int CW = $clog2(BASE_DIV);
    localparam int SW = $clog2(N_SPEED);
    localparam logic [SW-1:0] SPEED_MAX = SW'(N_SPEED - 1);

    logic [CW-1:0] cnt_r;
    logic [SW-1:0] speed_r;
    logic [SW-1:0] speed_nxt_s;
    logic          spd_chg_s;
    logic          tick_r;
    logic          wrap_s;
    logic [31:0]   div_s;

    // Saturating speed update; simultaneous up and down pulses cancel.
    always_comb begin
        speed_nxt_s = speed_r;
        spd_chg_s   = 1'b0;
        if (speed_up && !speed_dn && (speed_r != SPEED_MAX)) begin
            speed_nxt_s = speed_r + SW'(1);
            spd_chg_s   = 1'b1;
        end else if (speed_dn && !speed_up && (speed_r != SW'(0))) begin
            speed_nxt_s = speed_r - SW'(1);
            spd_chg_s   = 1'b1;
        end else begin
            speed_nxt_s = speed_r;
            spd_chg_s   = 1'b0;
        end
    end

    // A clear or an effective speed change restarts the period and swallows a coinciding wrap.
    always_comb begin
        div_s  = 32'(BASE_DIV) >> speed_r;
        wrap_s = en && !clr && !spd_chg_s &&
                 ({{(32-CW){1'b0}}, cnt_r} == (div_s - 32'd1));
    end

    // Counter, speed and tick registers.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            speed_r <= '0;
            tick_r  <= 1'b0;
        end else begin
            speed_r <= speed_nxt_s;
            tick_r  <= wrap_s;
            if (clr || spd_chg_s) begin
                cnt_r <= '0;
            end else if (wrap_s) begin
                cnt_r <= '0;
            end else if (en) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign speed = speed_r;
    assign tick  = tick_r;
    assign step  = wrap_s;

endmodule

// File: rtl/led_flow_ctrl.sv
// LED-flow sequencer top: run/pause/reload FSM and pattern register stepped by led_tick_gen.
// Optional LED_FLOW_PINGPONG_EN enables the PINGPONG pattern (mode 3); otherwise mode 3 is SHIFT_L.
module led_flow_ctrl
    import led_flow_pkg::*;
#(
    parameter int N_LED    = 8,
    parameter int BASE_DIV = 250000,
    parameter int N_SPEED  = 4
) (
    input  logic                       clkin,
    input  logic                       rst_n,
    input  logic                       run,
    input  logic                       speed_up,
    input  logic                       speed_dn,
    input  logic [1:0]                 mode_sel,
    input  logic                       mode_load,
    output logic [N_LED-1:0]           led,
    output logic [$clog2(N_SPEED)-1:0] speed,
    output logic                       tick
);

    localparam logic [N_LED-1:0] LED_LSB = {{(N_LED-1){1'b0}}, 1'b1};
    localparam logic [N_LED-1:0] LED_MSB = {1'b1, {(N_LED-1){1'b0}}};

    state_e           state_r;
    state_e           state_s;
    mode_e            mode_r;
    logic [N_LED-1:0] led_r;
    logic [N_LED-1:0] next_led_s;
    logic [N_LED-1:0] start_led_s;
    logic             en_s;
    logic             clr_s;
    logic             step_s;
`ifdef LED_FLOW_PINGPONG_EN
    dir_e             dir_r;
    dir_e             next_dir_s;
`endif

    // Next-state decode; a mode load preempts everything else.
    always_comb begin
        state_s = state_r;
        if (mode_load) begin
            state_s = ST_RELOAD;
        end else begin
            case (state_r)
                ST_IDLE:   state_s = run ? ST_RUN : ST_IDLE;
                ST_RUN:    state_s = run ? ST_RUN : ST_IDLE;
                ST_RELOAD: state_s = run ? ST_RUN : ST_IDLE;
                default:   state_s = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Divider runs only in RUN; it holds its count in IDLE so a resume keeps the remainder.
    always_comb begin
        en_s  = (state_r == ST_RUN);
        clr_s = mode_load || (state_r == ST_RELOAD);
    end

    led_tick_gen #(
        .BASE_DIV (BASE_DIV),
        .N_SPEED  (N_SPEED)
    ) u_tick_gen (
        .clkin    (clkin),
        .rst_n    (rst_n),
        .en       (en_s),
        .clr      (clr_s),
        .speed_up (speed_up),
        .speed_dn (speed_dn),
        .speed    (speed),
        .tick     (tick),
        .step     (step_s)
    );

    // Start value loaded on a mode change, decoded from the incoming selection.
    always_comb begin
        start_led_s = LED_LSB;
        case (mode_e'(mode_sel))
            MODE_SHIFT_L:  start_led_s = LED_LSB;
            MODE_SHIFT_R:  start_led_s = LED_MSB;
            MODE_FILL:     start_led_s = '0;
            MODE_PINGPONG: start_led_s = LED_LSB;
            default:       start_led_s = LED_LSB;
        endcase
    end

    // One pattern step for the latched mode.
    always_comb begin
        next_led_s = led_r;
`ifdef LED_FLOW_PINGPONG_EN
        next_dir_s = dir_r;
`endif
        case (mode_r)
            MODE_SHIFT_L: next_led_s = {led_r[N_LED-2:0], led_r[N_LED-1]};
            MODE_SHIFT_R: next_led_s = {led_r[0], led_r[N_LED-1:1]};
            MODE_FILL: begin
                if (&led_r) begin
                    next_led_s = '0;
                end else begin
                    next_led_s = {led_r[N_LED-2:0], 1'b1};
                end
            end
            MODE_PINGPONG: begin
`ifdef LED_FLOW_PINGPONG_EN
                // Bounce off either end: the end bit turns the direction and steps back inward.
                if (led_r[N_LED-1]) begin
                    next_dir_s = DIR_RIGHT;
                    next_led_s = led_r >> 1;
                end else if (led_r[0] && (dir_r == DIR_RIGHT)) begin
                    next_dir_s = DIR_LEFT;
                    next_led_s = led_r << 1;
                end else if (dir_r == DIR_RIGHT) begin
                    next_led_s = led_r >> 1;
                end else begin
                    next_led_s = led_r << 1;
                end
`else
                next_led_s = {led_r[N_LED-2:0], led_r[N_LED-1]};
`endif
            end
            default: next_led_s = led_r;
        endcase
    end

    // Pattern, mode and direction registers; a reload wins over a coinciding step.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            led_r  <= LED_LSB;
            mode_r <= MODE_SHIFT_L;
`ifdef LED_FLOW_PINGPONG_EN
            dir_r  <= DIR_LEFT;
`endif
        end else if (mode_load) begin
            led_r  <= start_led_s;
            mode_r <= mode_e'(mode_sel);
`ifdef LED_FLOW_PINGPONG_EN
            dir_r  <= DIR_LEFT;
`endif
        end else if (step_s) begin
            led_r  <= next_led_s;
            mode_r <= mode_r;
`ifdef LED_FLOW_PINGPONG_EN
            dir_r  <= next_dir_s;
`endif
        end else begin
            led_r  <= led_r;
            mode_r <= mode_r;
`ifdef LED_FLOW_PINGPONG_EN
            dir_r  <= dir_r;
`endif
        end
    end

    assign led = led_r;

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Directed bench for led_flow_ctrl (N_LED=8, BASE_DIV=8, N_SPEED=4): vector table plus corner sequences.
module tb_led_flow_ctrl;

    localparam int N_LED    = 8;
    localparam int BASE_DIV = 8;
    localparam int N_SPEED  = 4;

    logic       clkin = 1'b0;
    logic       rst_n;
    logic       run;
    logic       speed_up;
    logic       speed_dn;
    logic [1:0] mode_sel;
    logic       mode_load;
    logic [7:0] led;
    logic [1:0] speed;
    logic       tick;

    int total = 0;
    int bad   = 0;

    always #5 clkin = ~clkin;

    led_flow_ctrl #(
        .N_LED    (N_LED),
        .BASE_DIV (BASE_DIV),
        .N_SPEED  (N_SPEED)
    ) dut (
        .clkin     (clkin),
        .rst_n     (rst_n),
        .run       (run),
        .speed_up  (speed_up),
        .speed_dn  (speed_dn),
        .mode_sel  (mode_sel),
        .mode_load (mode_load),
        .led       (led),
        .speed     (speed),
        .tick      (tick)
    );

    typedef struct {
        logic       run;
        logic       up;
        logic       dn;
        logic [1:0] msel;
        logic       load;
        int         ncyc;
        logic [7:0] led;
        logic       tick;
        logic [1:0] spd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic u, input logic d, input int n,
                                input logic [7:0] l, input logic t, input logic [1:0] s);
        vec_t v;
        v.run = r; v.up = u; v.dn = d; v.msel = 2'd0; v.load = 1'b0;
        v.ncyc = n; v.led = l; v.tick = t; v.spd = s;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clkin);
        @(negedge clkin);
    endtask

    task automatic apply(input vec_t v);
        run = v.run; speed_up = v.up; speed_dn = v.dn; mode_sel = v.msel; mode_load = v.load;
        cyc();
        speed_up = 1'b0; speed_dn = 1'b0; mode_load = 1'b0;
        for (int i = 1; i < v.ncyc; i++) cyc();
    endtask

    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while ((tick !== 1'b1) && (n < budget));
    endtask

    logic [7:0] shl_seq [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] fill_seq [9] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
`ifdef LED_FLOW_PINGPONG_EN
    logic [7:0] m3_seq [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
`else
    logic [7:0] m3_seq [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01,
                                8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
`endif

    initial begin
        int         n;
        logic       ok;
        logic [7:0] prev;

        // Test 1 table: first tick after FSM entry + 8 cycles, then every 8; wrap 80 -> 01.
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1, 8'h01, 1'b0, 2'd0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 7, 8'h01, 1'b0, 2'd0));
        prev = 8'h01;
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1, shl_seq[i], 1'b1, 2'd0));
            if (i < 7) vecs.push_back(mk(1'b1, 1'b0, 1'b0, 7, shl_seq[i], 1'b0, 2'd0));
        end
        // speed_dn at 0 saturates; up+dn together is a no-op
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1, 8'h01, 1'b0, 2'd0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1, 8'h01, 1'b0, 2'd0));

        rst_n = 1'b0; run = 1'b0; speed_up = 1'b0; speed_dn = 1'b0;
        mode_sel = 2'd0; mode_load = 1'b0;
        @(negedge clkin);
        cyc();
        check("reset_led", 32'(led), 32'h01);
        check("reset_speed", 32'(speed), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].led));
            check($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].tick));
            check($sformatf("vec%0d_speed", i), 32'(speed), 32'(vecs[i].spd));
        end

        // Test 2: speed up to 3 (4th saturates), then a step every cycle.
        for (int i = 1; i <= 4; i++) begin
            speed_up = 1'b1;
            cyc();
            speed_up = 1'b0;
            check($sformatf("spdup%0d_speed", i), 32'(speed), (i == 4) ? 32'd3 : 32'(i));
            check($sformatf("spdup%0d_tick", i), 32'(tick), (i == 4) ? 32'd1 : 32'd0);
            check($sformatf("spdup%0d_led", i), 32'(led), (i == 4) ? 32'h02 : 32'h01);
        end
        prev = 8'h02;
        for (int i = 0; i < 3; i++) begin
            cyc();
            prev = prev << 1;
            check($sformatf("fast%0d_led", i), 32'(led), 32'(prev));
            check($sformatf("fast%0d_tick", i), 32'(tick), 32'd1);
        end
        for (int i = 0; i < 3; i++) begin
            speed_dn = 1'b1;
            cyc();
            speed_dn = 1'b0;
            check($sformatf("spddn%0d_speed", i), 32'(speed), 32'(2 - i));
            check($sformatf("spddn%0d_led", i), 32'(led), 32'h10);
        end

        // Test 3: pause at cnt=5 holds led; resume ticks 3 cycles later.
        for (int i = 0; i < 5; i++) cyc();
        run = 1'b0;
        cyc();
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (led !== 8'h10 || tick !== 1'b0) ok = 1'b0;
        end
        check("pause_frozen", 32'(ok), 32'd1);
        run = 1'b1;
        wait_tick(20, n);
        check("resume_latency", 32'(n), 32'd3);
        check("resume_led", 32'(led), 32'h20);

        // Test 4: mode_load of FILL on a tick cycle discards the step.
        for (int i = 0; i < 7; i++) cyc();
        mode_sel = 2'd2; mode_load = 1'b1;
        cyc();
        mode_load = 1'b0;
        check("reload_led", 32'(led), 32'h00);
        check("reload_tick", 32'(tick), 32'd0);
        for (int k = 0; k < 9; k++) begin
            wait_tick(20, n);
            check($sformatf("fill%0d_gap", k), 32'(n), (k == 0) ? 32'd9 : 32'd8);
            check($sformatf("fill%0d_led", k), 32'(led), 32'(fill_seq[k]));
        end

        // Test 5: mode 3 (PINGPONG when enabled, otherwise SHIFT_L).
        mode_sel = 2'd3; mode_load = 1'b1;
        cyc();
        mode_load = 1'b0;
        check("m3_start_led", 32'(led), 32'h01);
        for (int k = 0; k < 15; k++) begin
            wait_tick(20, n);
            check($sformatf("m3_%0d_gap", k), 32'(n), (k == 0) ? 32'd9 : 32'd8);
            check($sformatf("m3_%0d_led", k), 32'(led), 32'(m3_seq[k]));
        end

        // Test 6: reset mid-run at speed 2 overrides a pending pulse.
        for (int i = 0; i < 2; i++) begin
            speed_up = 1'b1;
            cyc();
            speed_up = 1'b0;
        end
        check("pre_rst_speed", 32'(speed), 32'd2);
        for (int i = 0; i < 5; i++) cyc();
        rst_n = 1'b0; speed_up = 1'b1;
        cyc();
        rst_n = 1'b1; speed_up = 1'b0;
        check("midrst_led", 32'(led), 32'h01);
        check("midrst_speed", 32'(speed), 32'd0);
        check("midrst_tick", 32'(tick), 32'd0);
        wait_tick(30, n);
        check("post_rst_latency", 32'(n), 32'd9);
        check("post_rst_led", 32'(led), 32'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
